aes_sbox_pipe: RTL
==================

# aes_sbox_pipe

Parametrised, pipelined AES byte-substitution unit that processes LANES bytes per beat in forward (SubBytes) or inverse (InvSubBytes) mode. Each lane computes the GF(2^8) multiplicative inverse in composite-field form GF((2^4)^2), reusing a GF(2^4) inverter. Affine and inverse-affine transforms are selected per beat. The block sits between the round-key/state datapath and ShiftRows, behind a valid/ready handshake with full backpressure.

## Interface
- LANES, 4, bytes processed in parallel per beat (1..16)
- STAGES, 2, pipeline register stages, legal values 1, 2 or 3; also the latency in cycles
- clk_i  input  1  clock; all state updates on the rising edge
- rst_ni  input  1  reset, synchronous, active-low
- valid_i  input  1  input beat valid
- ready_o  output  1  block accepts a beat this cycle
- mode_i  input  1  0 = forward S-box, 1 = inverse S-box; sampled with the beat
- data_i  input  8*LANES  input bytes, lane k = data_i[8k+7:8k]
- valid_o  output  1  output beat valid
- ready_i  input  1  downstream accepts output
- data_o  output  8*LANES  substituted bytes, same lane ordering

## Operation
- Per lane, forward: y = A(inv(x)) ^ 0x63. Inverse: y = inv(A^-1(x ^ 0x63)). A is the AES affine matrix. inv(0) = 0.
- inv(x) in composite field:
  - Map x through isomorphism matrix M to (ah, al) in GF(16).
  - d = λ·ah² ^ ah·al ^ al².
  - e = d^-1 via the GF(2^4) inverter.
  - ah' = ah·e, al' = (ah ^ al)·e.
  - Map back through M^-1.
- GF(16) multiply, square and λ-scale are polynomial-basis, reduced by x^4+x+1. All arithmetic is XOR/AND; no carries and no width growth.
- mode_i travels down the pipeline with its beat. Mixed modes on consecutive beats are legal and must not interfere.
- Stage cut points:
  - STAGES=1: register at output only.
  - STAGES=2: additionally after e (inverter output) registered with ah, al.
  - STAGES=3: additionally after the input map/pre-affine.
- Pipeline control is a global stall.
  - stall = valid_o & ~ready_i.
  - When stalled, every stage holds its data and valid bit.
  - Otherwise every stage advances; stage 0 loads valid_i & ready_o.
  - ready_o = ~stall.
  - Bubbles are not collapsed.
- A beat transfers in when valid_i & ready_o, and transfers out when valid_o & ready_i.
- Data registers of invalid stages may load freely. data_o is only meaningful when valid_o = 1.

## Timing
- Reset (rst_ni = 0 at a rising edge):
  - All stage valid bits, valid_o and data_o go to 0.
  - ready_o is 1 from the cycle after reset, because valid_o = 0.
- Reset mid-operation discards all in-flight beats; no partial output is ever presented.
- Latency: a beat accepted at edge n appears on valid_o/data_o after edge n+STAGES-1. It is visible in cycle n+STAGES with no stall.
- Throughput: one beat per cycle while ready_i = 1.
- Backpressure:
  - While valid_o & ~ready_i, data_o and valid_o are held stable and ready_o = 0.
  - Input is ignored; valid_i may toggle without effect.
- Simultaneous ready_i rise and new valid_i: the pipeline advances and accepts in the same cycle.
- No combinational path from ready_i to data_o. ready_i → ready_o is combinational by design, a single AND with valid_o.

## Structure
- Shared package aes_gf_pkg holds:
  - isomorphism matrices M and M^-1 (8×8 bit constants)
  - AES affine matrix and constant 0x63
  - λ constant
  - functions gf16_mul, gf16_sq, gf16_scale_lambda
  - typedef byte_t (logic [7:0])
  - typedef nibble_t (logic [3:0])
- Sub-module: aes_sbox_lane is one combinational lane, split into pre/post sections by STAGES-dependent register insertion in the parent. It instantiates the existing GF(2^4) inverter.
- The parent generates LANES lanes plus the shared valid/mode pipeline and stall logic.
- Elaboration-time assertion: STAGES in {1,2,3}, LANES in 1..16.

## Test plan
- Known vectors, LANES=4, mode 0, data_i = 0x53_01_00_FF → data_o = 0xED_7C_63_16 after STAGES cycles.
- Inverse mode, data_i = 0xED_7C_63_16 → 0x53_01_00_FF. Check inverse vs forward round-trip for all 256 values in every lane.
- Alternating mode_i every beat with continuous valid_i and ready_i = 1 → each output matches its own beat's mode, one beat per cycle.
- Backpressure: drop ready_i for 5 cycles while streaming.
  - valid_o/data_o held, ready_o = 0.
  - No beat lost or duplicated; output sequence equals input sequence.
- Reset asserted with 2 beats in flight → valid_o = 0 and data_o = 0 next cycle. First post-reset beat emerges with correct latency.
- Sweep STAGES = 1, 2, 3 and LANES = 1, 16 → latency equals STAGES and the results are identical across configurations.

Source files
------------

// File: rtl/aes_gf_pkg.sv
// Shared GF(2^4)/GF((2^4)^2) arithmetic, matrices and types for the AES S-box datapath.
// Composite field: GF(16) = GF(2)[x]/(x^4+x+1), GF(256) = GF(16)[y]/(y^2+y+LAMBDA).
package aes_gf_pkg;

  typedef logic [7:0] byte_t;
  typedef logic [3:0] nibble_t;
  typedef logic [7:0][7:0] mat8_t;  // mat[i] is the row producing output bit i

  localparam byte_t   AFF_C  = 8'h63;
  localparam nibble_t LAMBDA = 4'hC;

  localparam mat8_t AFF_M   = {8'hF8, 8'h7C, 8'h3E, 8'h1F, 8'h8F, 8'hC7, 8'hE3, 8'hF1};
  localparam mat8_t AFF_INV = {8'h52, 8'h29, 8'h94, 8'h4A, 8'h25, 8'h92, 8'h49, 8'hA4};

  function automatic byte_t mat_mul8(input mat8_t m, input byte_t x);
    byte_t r;
    for (int i = 0; i < 8; i++) r[i] = ^(m[i] & x);
    return r;
  endfunction

  function automatic nibble_t gf16_mul(input nibble_t a, input nibble_t b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ ({3'b000, a} << i);
    for (int i = 6; i >= 4; i--) if (p[i]) p = p ^ (7'b0010011 << (i - 4));
    return p[3:0];
  endfunction

  function automatic nibble_t gf16_sq(input nibble_t a);
    return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
  endfunction

  function automatic nibble_t gf16_scale_lambda(input nibble_t a);
    return gf16_mul(a, LAMBDA);
  endfunction

  // Product in the composite field, byte = {high nibble, low nibble}
  function automatic byte_t comp_mul(input byte_t a, input byte_t b);
    nibble_t hh;
    hh = gf16_mul(a[7:4], b[7:4]);
    return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
            gf16_scale_lambda(hh) ^ gf16_mul(a[3:0], b[3:0])};
  endfunction

  function automatic byte_t aes_poly_at(input byte_t b);
    byte_t p2, p4;
    p2 = comp_mul(b, b);
    p4 = comp_mul(p2, p2);
    return comp_mul(p4, p4) ^ p4 ^ comp_mul(p2, b) ^ b ^ 8'h01;
  endfunction

  // Columns of M are powers of a composite-field root of the AES polynomial
  function automatic mat8_t iso_m();
    byte_t beta, pw;
    mat8_t m;
    beta = '0;
    for (int c = 1; c < 256; c++)
      if (beta == 8'h00 && aes_poly_at(c[7:0]) == 8'h00) beta = c[7:0];
    pw = 8'h01;
    m  = '0;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 8; i++) m[i][j] = pw[i];
      pw = comp_mul(pw, beta);
    end
    return m;
  endfunction

  function automatic mat8_t iso_m_inv(input mat8_t m);
    mat8_t r;
    byte_t y;
    r = '0;
    for (int x = 0; x < 256; x++) begin
      y = mat_mul8(m, x[7:0]);
      for (int i = 0; i < 8; i++)
        if (y == (8'h01 << i))
          for (int b = 0; b < 8; b++) r[b][i] = x[b];
    end
    return r;
  endfunction

  localparam mat8_t ISO_M     = iso_m();
  localparam mat8_t ISO_M_INV = iso_m_inv(ISO_M);

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane, exposed as three sections so the parent can cut it
// after the input map (map_*) and after the GF(16) inverter (mid_* = {ah, al, e}).
module aes_sbox_lane
  import aes_gf_pkg::*;
(
  input  logic        mode_a_i,
  input  byte_t       x_i,
  output byte_t       map_o,
  input  byte_t       map_i,
  output logic [11:0] mid_o,
  input  logic [11:0] mid_i,
  input  logic        mode_c_i,
  output byte_t       y_o
);

  byte_t   pre_a, inv_c;
  nibble_t d_b, e_b, ah_c, al_c, e_c;

  always_comb begin
    pre_a = mode_a_i ? mat_mul8(AFF_INV, x_i ^ AFF_C) : x_i;
    map_o = mat_mul8(ISO_M, pre_a);
  end

  always_comb
    d_b = gf16_scale_lambda(gf16_sq(map_i[7:4])) ^ gf16_mul(map_i[7:4], map_i[3:0]) ^
          gf16_sq(map_i[3:0]);

  gf16_inv u_inv (
    .a_i (d_b),
    .y_o (e_b)
  );

  assign mid_o = {map_i, e_b};

  always_comb begin
    ah_c  = mid_i[11:8];
    al_c  = mid_i[7:4];
    e_c   = mid_i[3:0];
    inv_c = mat_mul8(ISO_M_INV, {gf16_mul(ah_c, e_c), gf16_mul(ah_c ^ al_c, e_c)});
    y_o   = mode_c_i ? inv_c : (mat_mul8(AFF_M, inv_c) ^ AFF_C);
  end

endmodule

// File: rtl/gf16_inv.sv
// Combinational GF(2^4) inverter: a^-1 = a^14 = a^8 * a^4 * a^2, which also maps 0 to 0.
module gf16_inv
  import aes_gf_pkg::*;
(
  input  nibble_t a_i,
  output nibble_t y_o
);

  nibble_t a2, a4, a8;

  always_comb begin
    a2  = gf16_sq(a_i);
    a4  = gf16_sq(a2);
    a8  = gf16_sq(a4);
    y_o = gf16_mul(gf16_mul(a8, a4), a2);
  end

endmodule

// File: rtl/aes_sbox_pipe.sv
// Pipelined LANES-wide AES SubBytes/InvSubBytes with a global-stall valid/ready pipeline.
// Register cuts: output always; after the inverter for STAGES>=2; after the input map for STAGES=3.
module aes_sbox_pipe
  import aes_gf_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               mode_i,
  input  logic [8*LANES-1:0] data_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [8*LANES-1:0] data_o
);

  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("aes_sbox_pipe: STAGES must be 1, 2 or 3");
  end
  if (LANES < 1 || LANES > 16) begin : g_bad_lanes
    $error("aes_sbox_pipe: LANES must be in 1..16");
  end

  logic                   stall, in_fire, mode_c;
  logic [STAGES-1:0]      vld_q, vld_d;
  byte_t [LANES-1:0]      map_c, map_s, y_c, out_q, out_d;
  logic [LANES-1:0][11:0] mid_c, mid_s;

  assign stall   = vld_q[STAGES-1] & ~ready_i;
  assign ready_o = ~stall;
  assign in_fire = valid_i & ready_o;
  assign valid_o = vld_q[STAGES-1];
  assign data_o  = out_q;

  // Bubbles travel like beats; only a full stall freezes the shift
  always_comb vld_d = stall ? vld_q : ((vld_q << 1) | STAGES'(in_fire));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) vld_q <= '0;
    else         vld_q <= vld_d;
  end

  if (STAGES > 1) begin : g_mode
    localparam int unsigned MW = STAGES - 1;
    logic [MW-1:0] mode_q, mode_d;

    always_comb mode_d = stall ? mode_q : ((mode_q << 1) | MW'(mode_i));

    always_ff @(posedge clk_i) begin
      if (!rst_ni) mode_q <= '0;
      else         mode_q <= mode_d;
    end

    assign mode_c = mode_q[MW-1];
  end else begin : g_mode_comb
    assign mode_c = mode_i;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    aes_sbox_lane u_lane (
      .mode_a_i (mode_i),
      .x_i      (data_i[8*k +: 8]),
      .map_o    (map_c[k]),
      .map_i    (map_s[k]),
      .mid_o    (mid_c[k]),
      .mid_i    (mid_s[k]),
      .mode_c_i (mode_c),
      .y_o      (y_c[k])
    );
  end

  if (STAGES == 3) begin : g_cut_map
    byte_t [LANES-1:0] map_q, map_d;

    always_comb map_d = stall ? map_q : map_c;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) map_q <= '0;
      else         map_q <= map_d;
    end

    assign map_s = map_q;
  end else begin : g_wire_map
    assign map_s = map_c;
  end

  if (STAGES >= 2) begin : g_cut_mid
    logic [LANES-1:0][11:0] mid_q, mid_d;

    always_comb mid_d = stall ? mid_q : mid_c;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) mid_q <= '0;
      else         mid_q <= mid_d;
    end

    assign mid_s = mid_q;
  end else begin : g_wire_mid
    assign mid_s = mid_c;
  end

  always_comb out_d = stall ? out_q : y_c;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) out_q <= '0;
    else         out_q <= out_d;
  end

endmodule
